// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and the
// default identification word returned by register 0.
package apb_pkg;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = 4;

    localparam logic [APB_DATA_W-1:0] APB_DEFAULT_ID = 32'hA9B0_0001;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_regbank.sv
// Register storage for the APB completer.
// NUM_REGS x 32-bit registers with a byte-strobed write port and an
// asynchronous read port. Register 0 is hard-wired to ID_VALUE and
// ignores writes.
// Ports:
//   pclk   - clock, rising edge
//   preset - asynchronous reset, active-low (clears regs 1..NUM_REGS-1)
//   we     - write enable
//   widx   - write register index
//   wdata  - write data
//   wstrb  - byte lane enables, wstrb[i] -> wdata[8i+7:8i]
//   ridx   - read register index
//   rdata  - read data (combinational)
module apb_regbank
    import apb_pkg::*;
#(
    parameter int unsigned             NUM_REGS = 16,
    parameter logic [APB_DATA_W-1:0]   ID_VALUE = APB_DEFAULT_ID,
    localparam int unsigned            IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [APB_STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    // regs[0] is reset and never written; reads of index 0 bypass it.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (widx != '0)) begin
            for (int unsigned b = 0; b < APB_STRB_W; b++) begin
                if (wstrb[b]) begin
                    regs[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = (ridx == '0) ? ID_VALUE : regs[ridx];
    end

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer with a bank of 32-bit registers, byte-strobe writes,
// programmable wait states and error signalling on pslverr.
// Ports:
//   pclk    - clock, rising edge
//   preset  - asynchronous reset, active-low
//   psel    - select for this completer
//   penable - access phase marker
//   paddr   - byte address
//   pwrite  - 1 = write, 0 = read
//   pprot   - protection attributes (accepted, not checked)
//   pwdata  - write data
//   pstrb   - byte lane enables
//   prdata  - read data, valid with pready on an error-free read, else 0
//   pready  - transfer completion
//   pslverr - transfer error, asserted only together with pready
module apb_completer_regs
    import apb_pkg::*;
#(
    parameter int unsigned           ADDR_W      = 32,
    parameter int unsigned           NUM_REGS    = 16,
    parameter int unsigned           WAIT_STATES = 1,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = APB_DEFAULT_ID
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic                  pwrite,
    input  logic [2:0]            pprot,
    input  logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_STRB_W-1:0] pstrb,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned       IDX_W      = $clog2(NUM_REGS);
    localparam logic [3:0]        WS         = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

    apb_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]      idx;
    logic                  err;
    logic                  commit;
    logic [APB_DATA_W-1:0] rd_data;

    logic unused_pprot;
    assign unused_pprot = ^pprot;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A psel drop is checked before completion, so an abort wins over a
    // counter that would otherwise reach WAIT_STATES in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (psel) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    if (cnt_q == WS) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pready = (state_q == ACCESS) & psel & penable & (cnt_q == WS);

    assign idx    = paddr[IDX_W+1:2];
    assign err    = (paddr[1:0] != 2'b00)
                  | (paddr >= ADDR_LIMIT)
                  | (pwrite & (idx == '0));
    assign commit = pready & pwrite & ~err;

    apb_regbank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .pclk   (pclk),
        .preset (preset),
        .we     (commit),
        .widx   (idx),
        .wdata  (pwdata),
        .wstrb  (pstrb),
        .ridx   (idx),
        .rdata  (rd_data)
    );

    assign prdata  = (pready & ~pwrite & ~err) ? rd_data : '0;
    assign pslverr = pready & err;

endmodule

// File: tb/tb_apb_completer_regs.sv
module tb_apb_completer_regs;

    localparam logic [31:0] ID  = 32'hA9B0_0001;
    localparam int          WS0 = 1;
    localparam int          WS1 = 0;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [31:0] prdata_w  [2];
    logic        pready_w  [2];
    logic        pslverr_w [2];

    always #5 pclk = ~pclk;

    apb_completer_regs #(
        .ADDR_W      (32),
        .NUM_REGS    (16),
        .WAIT_STATES (WS0),
        .ID_VALUE    (ID)
    ) dut0 (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel[0]),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pprot   (pprot),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata_w[0]),
        .pready  (pready_w[0]),
        .pslverr (pslverr_w[0])
    );

    apb_completer_regs #(
        .ADDR_W      (32),
        .NUM_REGS    (16),
        .WAIT_STATES (WS1),
        .ID_VALUE    (ID)
    ) dut1 (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel[1]),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pprot   (pprot),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata_w[1]),
        .pready  (pready_w[1]),
        .pslverr (pslverr_w[1])
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int waits [2];

    // Reference register contents per instance (index 0 unused: ID is constant)
    logic [31:0] mem [2][16];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 16; r++)
                mem[k][r] = 32'h0;
    endfunction

    // Behavioural model: word-addressed array, errors from the address rules.
    function automatic exp_t model(int k, logic [31:0] addr, logic wr,
                                   logic [31:0] data, logic [3:0] strb);
        exp_t        e;
        int unsigned w = addr / 4;
        e.err   = (addr % 4 != 0) || (addr >= 64) || (wr && w == 0);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem[k][w][8*b +: 8] = data[8*b +: 8];
            end else begin
                e.rdata = (w == 0) ? ID : mem[k][w];
            end
        end
        return e;
    endfunction

    always @(negedge pclk) begin : monitor
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (!preset || !psel[k]) begin
                waits[k] = 0;
            end else if (penable) begin
                if (pready_w[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_completion[%0d]: got pready=1 expected no transfer pending", k);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("prdata[%0d] addr=%08h", k, paddr), prdata_w[k], e.rdata);
                        chk($sformatf("pslverr[%0d] addr=%08h", k, paddr), {31'b0, pslverr_w[k]}, {31'b0, e.err});
                        chk($sformatf("wait_states[%0d]", k), waits[k], (k == 0) ? WS0 : WS1);
                    end
                    waits[k] = 0;
                end else begin
                    waits[k]++;
                end
            end
        end
    end

    task automatic xfer(int k, logic [31:0] addr, logic wr, logic [31:0] data,
                        logic [3:0] strb, int hold);
        exp_t e;
        bit   done;
        e = model(k, addr, wr, data, strb);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        psel[k] = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = 3'($urandom);
        @(posedge pclk) #1;
        repeat (hold) @(posedge pclk) #1;
        penable = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge pclk);
            if (pready_w[k]) done = 1'b1;
        end
        if (done) begin
            @(posedge pclk) #1;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout[%0d] addr=%08h: got no pready expected completion within 20 cycles", k, addr);
            if (k == 0) void'(q0.pop_back());
            else        void'(q1.pop_back());
        end
        psel    = 2'b00;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          k, sel;

        preset  = 1'b0;
        psel    = 2'b00;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pprot   = '0;
        pwdata  = '0;
        pstrb   = '0;
        clear_model();

        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_pready[%0d]", i),  {31'b0, pready_w[i]},  32'h0);
            chk($sformatf("reset_pslverr[%0d]", i), {31'b0, pslverr_w[i]}, 32'h0);
            chk($sformatf("reset_prdata[%0d]", i),  prdata_w[i],           32'h0);
        end
        repeat (3) @(posedge pclk);
        #1 preset = 1'b1;
        @(posedge pclk) #1;

        // Full write then read, wait state counted by the monitor
        xfer(0, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 0);
        xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 0);

        // Partial strobes over reset value
        xfer(0, 32'h0C, 1'b1, 32'h12345678, 4'b1010, 0);
        xfer(0, 32'h0C, 1'b0, 32'h0, 4'h0, 0);

        // ID register is read-only
        xfer(0, 32'h00, 1'b1, 32'hFFFFFFFF, 4'hF, 0);
        xfer(0, 32'h00, 1'b0, 32'h0, 4'h0, 0);

        // Out of range and misaligned
        xfer(0, 32'h40, 1'b0, 32'h0, 4'h0, 0);
        xfer(0, 32'h06, 1'b0, 32'h0, 4'h0, 0);

        // Aborted write: psel dropped during the wait cycle
        psel[0] = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1;
        pwdata  = 32'hCAFEBABE; pstrb = 4'hF;
        @(posedge pclk) #1 penable = 1'b1;
        @(posedge pclk) #1 begin psel = 2'b00; penable = 1'b0; end
        @(posedge pclk) #1;
        xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 0);

        // pstrb=0 write: no change, no error
        xfer(0, 32'h04, 1'b1, 32'h11111111, 4'h0, 1);
        xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 0);

        // Reset in the middle of an access that is about to complete
        xfer(0, 32'h10, 1'b1, 32'h5555AAAA, 4'hF, 0);
        psel[0] = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1;
        pwdata  = 32'h12345678; pstrb = 4'hF;
        @(posedge pclk) #1 penable = 1'b1;
        @(posedge pclk) #1;
        chk("pready_before_reset", {31'b0, pready_w[0]}, 32'h1);
        preset = 1'b0;
        #1;
        chk("pready_in_reset",  {31'b0, pready_w[0]},  32'h0);
        chk("pslverr_in_reset", {31'b0, pslverr_w[0]}, 32'h0);
        chk("prdata_in_reset",  prdata_w[0],           32'h0);
        psel = 2'b00; penable = 1'b0;
        clear_model();
        @(posedge pclk) #1;
        @(posedge pclk) #1 preset = 1'b1;
        @(posedge pclk) #1;
        xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 0);

        // Zero wait states instance
        xfer(1, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 0);
        xfer(1, 32'h04, 1'b0, 32'h0, 4'h0, 0);
        xfer(1, 32'h00, 1'b0, 32'h0, 4'h0, 0);

        // Randomised traffic on both instances
        for (int n = 0; n < 120; n++) begin
            k   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = $urandom_range(0, 15) * 4;
            else if (sel == 7) a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
            else if (sel == 8) a = $urandom | 32'h40;
            else               a = 64 + $urandom_range(0, 15) * 4;
            xfer(k, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 4) == 0) ? 1 : 0);
            repeat ($urandom_range(0, 2)) @(posedge pclk) #1;
        end

        // Read back the whole bank of each instance
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 16; r++)
                xfer(i, r * 4, 1'b0, 32'h0, 4'h0, 0);

        repeat (3) @(posedge pclk);
        chk("pending_q0", q0.size(), 32'h0);
        chk("pending_q1", q1.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test expected finish before 500000");
        $fatal(1, "simulation time limit");
    end

endmodule
